ram_control_seq: RTL
====================

Name: ram_control_seq

Overview:
Parametrised successor to the fixed 256x16 control ROM. It holds a writable control-word store and adds a burst sequencer that streams a programmed run of words to a downstream consumer over a valid/ready interface. The store is loaded at runtime through a write port. The sequencer reads `count` consecutive words from `start_addr`, wrapping at the top of memory, and tolerates downstream back-pressure without losing or repeating words.

Parameters:
- DATA_W, 16, control word width in bits.
- ADDR_W, 8, address width; DEPTH = 2**ADDR_W words.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write strobe for the store.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- start  in  1  start burst; sampled only when busy=0.
- start_addr  in  ADDR_W  first word address, latched on accepted start.
- count  in  ADDR_W+1  number of words, 0..DEPTH; latched on accepted start.
- abort  in  1  cancel burst in progress.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse when a burst completes normally.
- out_valid  out  1  out_data/out_addr valid.
- out_ready  in  1  consumer accepts the word when out_valid&out_ready.
- out_data  out  DATA_W  streamed control word.
- out_addr  out  ADDR_W  address the streamed word came from.

Behaviour:
- Reset: busy=0, done=0, out_valid=0, out_data=0, out_addr=0, internal counters 0, state IDLE. Store contents are NOT cleared by rst.
- Store: DEPTH x DATA_W with one synchronous write and one synchronous read per cycle.
  - A write has effect at the edge where wr_en=1.
  - Same-cycle read and write to the same address returns the old data (read-first).
  - Writes are allowed in any state, including mid-burst.
- States:
  - IDLE:
    - start=1 with count>0 -> FETCH: latch rd_ptr=start_addr, remaining=count; busy=1 next cycle.
    - start=1 with count=0 -> DONE; no word is emitted.
  - FETCH: issues sequential reads. rd_ptr increments mod DEPTH (DEPTH-1 wraps to 0).
  - DRAIN: entered once all reads are issued; remains until every fetched word has been accepted.
  - DONE: done=1 and busy=0 for exactly one cycle -> IDLE.
- start while busy=1 is ignored, with no side effects.
- Latency: start sampled at edge E0; first read issued at E1; out_valid=1 after E2 with out_data=mem[start_addr].
- Throughput: with out_ready held 1, one word per cycle, no bubbles.
- Back-pressure:
  - While out_valid=1 and out_ready=0, out_data and out_addr hold stable.
  - The 2-entry skid buffer absorbs the in-flight read.
  - Issue stalls when the skid buffer is full.
  - No word is dropped or duplicated.
- Word order: words appear in address order, exactly `count` handshakes per burst.
- count=DEPTH reads the entire store once, starting at start_addr and wrapping.
- Completion: done pulses the cycle after the final handshake. busy falls in that same cycle.
- abort=1 in any non-IDLE state:
  - next cycle: IDLE, busy=0, out_valid=0, skid buffer flushed, no done pulse.
  - abort in IDLE has no effect.
  - abort has priority over a simultaneous handshake.
- rst mid-burst: same as abort, plus all outputs take their reset values.
- rst has priority over start, abort and wr_en. A write coinciding with rst is discarded.
- start and abort together in IDLE: the start is accepted.

Test Plan:
- Load mem[0..3] = 0x0000, 0x00C0, 0x0C18, 0x0001; start_addr=0, count=4, out_ready=1 -> out_valid first high 2 cycles after start; words 0x0000, 0x00C0, 0x0C18, 0x0001 on consecutive cycles; out_addr 0..3; done pulses once; busy low afterwards.
- Load mem[254]=0xAAAA, mem[255]=0xBBBB, mem[0]=0xCCCC; start_addr=254, count=3 -> words AAAA, BBBB, CCCC; out_addr 254, 255, 0.
- count=8 with out_ready toggled pseudo-randomly (including 3-cycle stalls) -> exactly 8 handshakes in order; data stable while stalled; scoreboard matches the store.
- count=0 -> done pulses 1 cycle after start; out_valid never asserted. A second start while busy in another burst -> ignored; the burst length remains the original count.
- Abort after 2 of 6 words accepted -> out_valid=0 and busy=0 next cycle; no done. A following start at 10 with count=1 -> streams mem[10] correctly.
- Write mem[5]=0x1234 in the same cycle the burst reads address 5 (old value 0x5555) -> 0x5555 is emitted; a later read of address 5 returns 0x1234. rst mid-burst -> all outputs 0 next cycle; store contents retained.

Source files
------------

// File: rtl/ram_control_seq.sv
// Writable control-word store with a burst sequencer that streams a run of
// consecutive words over valid/ready, absorbing back-pressure in a 2-entry skid buffer.
module ram_control_seq #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic [ADDR_W:0]   count_i,
  input  logic              abort_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [ADDR_W-1:0] out_addr_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   remaining_q, remaining_d;
  logic [ADDR_W:0]   pend_q, pend_d;

  logic              rd_valid_q, rd_valid_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] rd_data_q;

  logic [1:0]        skid_cnt_q, skid_cnt_d;
  logic [DATA_W-1:0] skid_data0_q, skid_data0_d;
  logic [DATA_W-1:0] skid_data1_q, skid_data1_d;
  logic [ADDR_W-1:0] skid_addr0_q, skid_addr0_d;
  logic [ADDR_W-1:0] skid_addr1_q, skid_addr1_d;

  logic              pop;
  logic              push;
  logic              issue;
  logic              abort_act;
  logic [2:0]        occ_next;

  assign pop       = out_valid_o & out_ready_i;
  assign push      = rd_valid_q;
  assign abort_act = abort_i && (state_q != S_IDLE);

  // Occupancy after this edge if nothing new is issued; a new read lands one edge later.
  assign occ_next = {1'b0, skid_cnt_q} + {2'b00, rd_valid_q} - {2'b00, pop};
  assign issue    = (state_q == S_FETCH) && !abort_i && (occ_next <= 3'd1);

  // Read-first store: the registered read sees the pre-write contents.
  always_ff @(posedge clk_i) begin
    if (wr_en_i && !rst_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (issue) begin
      rd_data_q <= mem_q[rd_ptr_q];
    end
  end

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    remaining_d = remaining_q;
    pend_d      = pend_q;
    rd_valid_d  = issue;
    rd_addr_d   = rd_addr_q;

    if (issue) begin
      rd_addr_d = rd_ptr_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (count_i != '0) begin
            state_d     = S_FETCH;
            rd_ptr_d    = start_addr_i;
            remaining_d = count_i;
            pend_d      = count_i;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_FETCH: begin
        if (issue) begin
          rd_ptr_d    = rd_ptr_q + ADDR_W'(1);
          remaining_d = remaining_q - (ADDR_W + 1)'(1);
          if (remaining_q == (ADDR_W + 1)'(1)) begin
            state_d = S_DRAIN;
          end
        end
        if (pop) begin
          pend_d = pend_q - (ADDR_W + 1)'(1);
        end
      end
      S_DRAIN: begin
        if (pop) begin
          pend_d = pend_q - (ADDR_W + 1)'(1);
          if (pend_q == (ADDR_W + 1)'(1)) begin
            state_d = S_DONE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort_act) begin
      state_d     = S_IDLE;
      remaining_d = '0;
      pend_d      = '0;
    end
  end

  // Head entry drives the outputs and only moves on a handshake.
  always_comb begin
    skid_cnt_d   = skid_cnt_q;
    skid_data0_d = skid_data0_q;
    skid_data1_d = skid_data1_q;
    skid_addr0_d = skid_addr0_q;
    skid_addr1_d = skid_addr1_q;

    case (skid_cnt_q)
      2'd0: begin
        if (push) begin
          skid_data0_d = rd_data_q;
          skid_addr0_d = rd_addr_q;
          skid_cnt_d   = 2'd1;
        end
      end
      2'd1: begin
        if (pop && push) begin
          skid_data0_d = rd_data_q;
          skid_addr0_d = rd_addr_q;
        end else if (pop) begin
          skid_cnt_d = 2'd0;
        end else if (push) begin
          skid_data1_d = rd_data_q;
          skid_addr1_d = rd_addr_q;
          skid_cnt_d   = 2'd2;
        end
      end
      default: begin
        if (pop) begin
          skid_data0_d = skid_data1_q;
          skid_addr0_d = skid_addr1_q;
          if (push) begin
            skid_data1_d = rd_data_q;
            skid_addr1_d = rd_addr_q;
          end else begin
            skid_cnt_d = 2'd1;
          end
        end
      end
    endcase

    if (abort_act) begin
      skid_cnt_d = 2'd0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      rd_ptr_q     <= '0;
      remaining_q  <= '0;
      pend_q       <= '0;
      rd_valid_q   <= 1'b0;
      rd_addr_q    <= '0;
      skid_cnt_q   <= 2'd0;
      skid_data0_q <= '0;
      skid_data1_q <= '0;
      skid_addr0_q <= '0;
      skid_addr1_q <= '0;
    end else begin
      state_q      <= state_d;
      rd_ptr_q     <= rd_ptr_d;
      remaining_q  <= remaining_d;
      pend_q       <= pend_d;
      rd_valid_q   <= rd_valid_d;
      rd_addr_q    <= rd_addr_d;
      skid_cnt_q   <= skid_cnt_d;
      skid_data0_q <= skid_data0_d;
      skid_data1_q <= skid_data1_d;
      skid_addr0_q <= skid_addr0_d;
      skid_addr1_q <= skid_addr1_d;
    end
  end

  assign busy_o      = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign done_o      = (state_q == S_DONE);
  assign out_valid_o = (skid_cnt_q != 2'd0);
  assign out_data_o  = skid_data0_q;
  assign out_addr_o  = skid_addr0_q;

endmodule
